// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// Port ids double as bit positions in the arbiter's request/grant vectors.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam int DEF_ADDR_W = 4;
  localparam int DEF_DATA_W = 8;

  localparam logic PORT_F = 1'b0;
  localparam logic PORT_D = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter: bit 0 = fetch, bit 1 = data.
// The grant is combinational; the last-served pointer moves only on an accepted grant.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] grant
);

  logic       last_r;
  logic [1:0] grant_s;

  // One-hot grant; on a tie, the port not served last wins
  always_comb begin
    grant_s = 2'b00;
    case (req)
      2'b01:   grant_s = 2'b01;
      2'b10:   grant_s = 2'b10;
      2'b11:   grant_s = (last_r == PORT_F) ? 2'b10 : 2'b01;
      default: grant_s = 2'b00;
    endcase
  end

  assign grant = grant_s;

  // Last-served pointer; reset favours fetch on the first tie
  always_ff @(posedge clk) begin
    if (rst) begin
      last_r <= PORT_D;
    end else if (accept) begin
      last_r <= grant_s[1] ? PORT_D : PORT_F;
    end else begin
      last_r <= last_r;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Fetch/data memory arbiter: one transaction in flight, fixed three-cycle
// IDLE -> ACCESS -> RESP sequence, round-robin tie-break between ports.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_req_valid,
  output logic              f_req_ready,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_rsp_valid,
  output logic [DATA_W-1:0] f_rdata,
  input  logic              d_req_valid,
  output logic              d_req_ready,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic              d_we,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_rsp_valid,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  state_t            state_r;
  state_t            state_nx_s;
  logic [1:0]        req_s;
  logic [1:0]        grant_s;
  logic              hs_s;
  logic              port_r;
  logic              we_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic              mem_read_r;
  logic              mem_write_r;
  logic [DATA_W-1:0] mem_wdata_r;
  logic              f_rsp_valid_r;
  logic              d_rsp_valid_r;
  logic [DATA_W-1:0] f_rdata_r;
  logic [DATA_W-1:0] d_rdata_r;

  // Requests are only visible to the arbiter in IDLE, so ready is IDLE-only
  assign req_s = {d_req_valid, f_req_valid} & {2{state_r == IDLE}};
  assign hs_s  = |(req_s & grant_s);

  rr_arb2 u_rr_arb2 (
    .clk    (clk),
    .rst    (rst),
    .req    (req_s),
    .accept (hs_s),
    .grant  (grant_s)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (hs_s) begin
          state_nx_s = ACCESS;
        end else begin
          state_nx_s = IDLE;
        end
      end
      ACCESS:  state_nx_s = RESP;
      RESP:    state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  // Request latch, memory strobes, response capture
  always_ff @(posedge clk) begin
    if (rst) begin
      port_r        <= PORT_F;
      we_r          <= 1'b0;
      mem_addr_r    <= '0;
      mem_read_r    <= 1'b0;
      mem_write_r   <= 1'b0;
      mem_wdata_r   <= '0;
      f_rsp_valid_r <= 1'b0;
      d_rsp_valid_r <= 1'b0;
      f_rdata_r     <= '0;
      d_rdata_r     <= '0;
    end else begin
      mem_addr_r    <= '0;
      mem_read_r    <= 1'b0;
      mem_write_r   <= 1'b0;
      mem_wdata_r   <= '0;
      f_rsp_valid_r <= 1'b0;
      d_rsp_valid_r <= 1'b0;
      if (hs_s) begin
        // Strobes are loaded here so they are high for exactly the ACCESS cycle
        port_r      <= grant_s[1] ? PORT_D : PORT_F;
        we_r        <= grant_s[1] & d_we;
        mem_addr_r  <= grant_s[1] ? d_addr : f_addr;
        mem_read_r  <= ~(grant_s[1] & d_we);
        mem_write_r <= grant_s[1] & d_we;
        mem_wdata_r <= (grant_s[1] & d_we) ? d_wdata : '0;
      end else if (state_r == ACCESS) begin
        if (port_r == PORT_D) begin
          d_rsp_valid_r <= 1'b1;
          d_rdata_r     <= we_r ? '0 : mem_rdata;
        end else begin
          f_rsp_valid_r <= 1'b1;
          f_rdata_r     <= mem_rdata;
        end
      end
    end
  end

  assign f_req_ready = grant_s[0];
  assign d_req_ready = grant_s[1];
  assign mem_addr    = mem_addr_r;
  assign mem_read    = mem_read_r;
  assign mem_wdata   = mem_wdata_r;
  // Reset must abort in-flight work immediately: no write lands, no response escapes
  assign mem_write   = mem_write_r & ~rst;
  assign f_rsp_valid = f_rsp_valid_r & ~rst;
  assign d_rsp_valid = d_rsp_valid_r & ~rst;
  assign f_rdata     = f_rdata_r;
  assign d_rdata     = d_rdata_r;
  assign busy        = (state_r != IDLE);

endmodule
